// File: rtl/axi_wbuf_queue.sv
// Write-back buffer: DEPTH-entry line FIFO drained oldest-first as AXI INCR bursts.
// Define WBUF_FORWARD_EN to build the queued-line lookup used by the refill path.
module axi_wbuf_queue #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic [LINE_W-1:0]     push_line,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  empty,
  output logic                  full,
  output logic                  wr_err,
  input  logic [ADDR_W-1:0]     lk_addr,
  output logic                  lk_hit,
  output logic [LINE_W-1:0]     lk_line
);
  localparam int BEATS = LINE_W / DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  state_t             state_r;
  logic [PTR_W-1:0]   head_r, tail_r;
  logic [CNT_W-1:0]   count_r;
  logic [7:0]         beat_r;
  logic               awvalid_r, wvalid_r, wlast_r, bready_r, wr_err_r;
  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [LINE_W-1:0]  line_mem [DEPTH];
  logic               push_fire_s, pop_fire_s, empty_s, full_s, more_s;

  assign empty_s     = (count_r == CNT_W'(0));
  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign push_fire_s = push_valid && !full_s;
  assign pop_fire_s  = bvalid && bready_r;
  // Entries left once the head is popped, counting a push landing in the same cycle.
  assign more_s      = (count_r != CNT_W'(1)) || push_fire_s;

  // Line storage: written at tail on push, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_fire_s) begin
      addr_mem[tail_r] <= push_addr;
      line_mem[tail_r] <= push_line;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else begin
      if (push_fire_s) tail_r <= tail_r + PTR_W'(1);
      if (pop_fire_s)  head_r <= head_r + PTR_W'(1);
      case ({push_fire_s, pop_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      wr_err_r  <= 1'b0;
      beat_r    <= 8'd0;
    end else begin
      wr_err_r <= pop_fire_s && (bresp != 2'b00);
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            state_r   <= ADDR;
            awvalid_r <= 1'b1;
          end
        end
        ADDR: begin
          if (awready) begin
            state_r   <= DATA;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            beat_r    <= 8'd0;
            wlast_r   <= (BEATS == 1);
          end
        end
        DATA: begin
          if (wready) begin
            if (wlast_r) begin
              state_r  <= RESP;
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
            end else begin
              beat_r  <= beat_r + 8'd1;
              wlast_r <= (beat_r == 8'(BEATS - 2));
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            bready_r <= 1'b0;
            if (more_s) begin
              state_r   <= ADDR;
              awvalid_r <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          wlast_r   <= 1'b0;
          bready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign push_ready = !full_s;
  assign empty      = empty_s;
  assign full       = full_s;
  assign awvalid    = awvalid_r;
  assign wvalid     = wvalid_r;
  assign wlast      = wlast_r;
  assign bready     = bready_r;
  assign wr_err     = wr_err_r;
  assign awaddr     = awvalid_r ? (addr_mem[head_r] & LINE_MASK) : {ADDR_W{1'b0}};
  assign wdata      = wvalid_r ? line_mem[head_r][beat_r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
  assign awlen      = 8'(BEATS - 1);
  assign awsize     = 3'($clog2(DATA_W / 8));
  assign awburst    = 2'b01;
  assign wstrb      = {(DATA_W/8){1'b1}};

`ifdef WBUF_FORWARD_EN
  logic                 hit_s;
  logic [LINE_W-1:0]    line_s;
  logic [PTR_W-1:0]     idx_s;

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    hit_s  = 1'b0;
    line_s = {LINE_W{1'b0}};
    idx_s  = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_r + PTR_W'(k);
      if ((CNT_W'(k) < count_r) &&
          ((addr_mem[idx_s] & LINE_MASK) == (lk_addr & LINE_MASK))) begin
        hit_s  = 1'b1;
        line_s = line_mem[idx_s];
      end else begin
        hit_s  = hit_s;
        line_s = line_s;
      end
    end
  end

  assign lk_hit  = hit_s;
  assign lk_line = line_s;
`else
  logic unused_lk_s;
  assign unused_lk_s = ^lk_addr;
  assign lk_hit      = 1'b0;
  assign lk_line     = {LINE_W{1'b0}};
`endif

endmodule

// File: doc/axi_wbuf_queue.md
# axi_wbuf_queue

Parametrised multi-entry write-back buffer between the cache and the AXI write channels. Dirty lines from the cache are pushed into a DEPTH-entry FIFO with their addresses. Each entry is then drained, oldest first, as one AXI INCR burst (AW, then W beats, then B). An optional address lookup lets the cache's refill path read a line that is still queued.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 512, cache line width in bits; must be a multiple of DATA_W
- DATA_W, 32, AXI data width; must be 32, 64 or 128
- DEPTH, 2, number of line entries; power of two, at least 2
- BEATS (derived), LINE_W/DATA_W; must be 256 or less

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- push_valid  in  1  cache offers a line
- push_ready  out  1  buffer accepts the line; equals !full
- push_addr  in  ADDR_W  line address; offset bits are ignored
- push_line  in  LINE_W  line data; beat k is bits [k*DATA_W +: DATA_W]
- awvalid / awready  out / in  1  AW handshake
- awaddr  out  ADDR_W  head address with the low log2(LINE_W/8) bits zeroed
- awlen  out  8  BEATS-1
- awsize  out  3  log2(DATA_W/8)
- awburst  out  2  2'b01 (INCR)
- wvalid / wready  out / in  1  W handshake
- wdata  out  DATA_W  current beat of the head entry
- wstrb  out  DATA_W/8  all ones
- wlast  out  1  final beat
- bvalid / bready  in / out  1  B handshake
- bresp  in  2  write response
- empty  out  1  no entries held
- full  out  1  DEPTH entries held
- wr_err  out  1  one-cycle pulse when a response is not OKAY
- lk_addr  in  ADDR_W  lookup address
- lk_hit  out  1  lookup matches a queued line
- lk_line  out  LINE_W  matching line

## Operation
- Storage is a FIFO of DEPTH entries: head and tail pointers are log2(DEPTH) bits and wrap naturally; a count of log2(DEPTH)+1 bits tracks occupancy.
- A push happens when push_valid && push_ready. The entry is written at tail and tail increments.
- The drain FSM has four states: IDLE, ADDR, DATA, RESP.
  - IDLE -> ADDR when the buffer is not empty.
  - ADDR: awvalid=1 and awaddr is driven. On awready the FSM goes to DATA and the beat counter is cleared.
  - DATA: wvalid=1. The beat counter increments on wvalid && wready. wlast = (beat == BEATS-1). The handshake on the last beat moves the FSM to RESP.
  - RESP: bready=1. On bvalid the head entry is popped (head increments, count decrements). The FSM then goes to ADDR if entries remain after the pop, otherwise to IDLE.
- wr_err pulses when bvalid && bready && bresp != 2'b00. The entry is still popped; no retry is made.
- awaddr is zero outside ADDR. wdata is zero outside DATA.
- The head entry is never overwritten while it is in flight. A push is accepted only while count < DEPTH.
- Simultaneous push and pop in one cycle: both take effect and count is unchanged. push_ready depends only on the registered full, so a pop in the same cycle does not free a slot for that cycle's push.
- Reset (asynchronous) clears pointers, count and FSM state, and drops all handshake outputs immediately, including in the middle of a burst. Line storage is not reset.

## Timing
- Reset values: awvalid=wvalid=wlast=bready=wr_err=0, empty=1, full=0, push_ready=1, lk_hit=0, awaddr=0, wdata=0. awlen, awsize, awburst and wstrb are constants.
- A push in cycle N updates empty/full in N+1. IDLE sees the new entry in N+1 and awvalid is asserted in N+2.
- With zero-wait AXI, one burst takes 1 (AW) + BEATS (W) + 1 or more (B) cycles. Back-to-back entries return to ADDR without passing through IDLE.
- wvalid is never deasserted mid-burst. Beats never skip or repeat under wready stalls.

## Configuration
- WBUF_FORWARD_EN defined:
  - lk_hit/lk_line are combinational from lk_addr and the valid entries, including the head in flight.
  - Addresses are compared with offset bits ignored. If several entries match, the youngest wins.
  - A push in the same cycle is not visible to the lookup.
- WBUF_FORWARD_EN undefined: no comparators are built, and lk_hit=0, lk_line=0 constantly.

## Test plan
- Default parameters, one push with addr 0x1000_0044, line[k]=k, zero-wait AXI:
  - awaddr=0x1000_0040, awlen=15, awsize=2.
  - 16 beats with wdata 0..15; wlast only on beat 15.
  - After bvalid: empty=1 and the FSM returns to IDLE.
- Random wready stalls (about 50%) on a single burst -> the wdata sequence is unchanged and wvalid stays high throughout DATA.
- Three pushes with DEPTH=2 and awready held low:
  - The third push is stalled (push_ready=0, full=1).
  - After the first B, the third push is accepted.
  - Bursts are issued in push order.
- Push offered in the same cycle as the B handshake while full -> push is not accepted that cycle, is accepted the next cycle, and count ends at 2.
- bresp=2'b10 on the first burst -> wr_err pulses for exactly one cycle, the entry is popped, and the next entry drains normally.
- WBUF_FORWARD_EN with entries at 0x2000 and 0x3000, lk_addr=0x3008:
  - lk_hit=1 and lk_line equals the 0x3000 data.
  - After that entry is popped, lk_hit=0.
  - Assert rstn low mid-burst -> wvalid drops immediately and empty=1.
